// File: rtl/stall_flush_ctrl_pkg.sv
// Shared pipeline hazard-control types.
//   hz_state_e : wait-state FSM encoding (RUN / MEM_WAIT / TIMEOUT, 2'd3 illegal)
//   hz_ctrl_t  : the seven stall/flush controls driven into the pipeline registers
package stall_flush_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    HzRun     = 2'd0,
    HzMemWait = 2'd1,
    HzTimeout = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctrl_t;

  localparam hz_ctrl_t HzCtrlNone = '0;

  // Freeze F..M and bubble into W while data memory is busy.
  localparam hz_ctrl_t HzCtrlMemStall = '{stall_f: 1'b1, stall_d: 1'b1, stall_e: 1'b1,
                                          stall_m: 1'b1, flush_d: 1'b0, flush_e: 1'b0,
                                          flush_w: 1'b1};

endpackage

// File: rtl/stall_flush_ctrl_hz_wait_timer.sv
// hz_wait_timer: saturating count of consecutive memory-wait cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : counter <- 0 (highest priority)
//   load       : counter <- 1 (first wait cycle)
//   inc        : counter + 1, saturating at all-ones
//   hit        : counter == WAIT_TIMEOUT
module hz_wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic hit
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CNT_W'(1);
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit = (cnt_q == CNT_W'(WAIT_TIMEOUT));

endmodule

// File: rtl/stall_flush_ctrl.sv
// stall_flush_ctrl: stall/flush generation for a 5-stage F/D/E/M/W pipeline.
// Handles load-use hazards, taken-branch redirects from E and data-memory waits,
// with a timeout on memory waits that latches a sticky error.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   Rs1_D/Rs2_D, UseRs*_D    : decode-stage sources and their use flags
//   Rd_E, MemRead_E, RegWrite_E, PCSrc_E : execute-stage destination/load/redirect
//   MemReq_M, MemReady_M     : M-stage memory access handshake
//   StallF/D/E/M, FlushD/E/W : pipeline register enables/clears
//   mem_timeout              : sticky, wait exceeded WAIT_TIMEOUT
//   state_o                  : FSM state (debug)
// Optional: define STALL_PERF_CNT_EN to add perf_lw_stalls, perf_mem_stalls,
// perf_flushes (32-bit wrapping event counters).
module stall_flush_ctrl
  import stall_flush_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 64,
  parameter int unsigned CNT_W        = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1_D,
  input  logic [REG_ADDR_W-1:0] Rs2_D,
  input  logic                  UseRs1_D,
  input  logic                  UseRs2_D,
  input  logic [REG_ADDR_W-1:0] Rd_E,
  input  logic                  MemRead_E,
  input  logic                  RegWrite_E,
  input  logic                  PCSrc_E,
  input  logic                  MemReq_M,
  input  logic                  MemReady_M,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushW,
  output logic                  mem_timeout,
  output logic [1:0]            state_o
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]           perf_lw_stalls,
  output logic [31:0]           perf_mem_stalls,
  output logic [31:0]           perf_flushes
`endif
);

  hz_state_e state_q, state_d;
  hz_ctrl_t  run_ctrl, ctrl;
  logic      lw_haz, mem_hold;
  logic      run_lw, run_br;
  logic      timeout_q, timeout_d;
  logic      tmr_clr, tmr_load, tmr_inc, tmr_hit;

  // x0 is hard-wired zero, so it can never be a real producer.
  assign lw_haz = MemRead_E & RegWrite_E & (Rd_E != '0) &
                  ((UseRs1_D & (Rs1_D == Rd_E)) | (UseRs2_D & (Rs2_D == Rd_E)));
  assign mem_hold = MemReq_M & ~MemReady_M;

  // Redirect beats load-use: the dependent instruction is squashed anyway.
  assign run_br = ~mem_hold & PCSrc_E;
  assign run_lw = ~mem_hold & ~PCSrc_E & lw_haz;

  always_comb begin
    run_ctrl = HzCtrlNone;
    if (mem_hold) begin
      // Branch in E is frozen with the rest of the pipe, not flushed.
      run_ctrl = HzCtrlMemStall;
    end else if (run_br) begin
      run_ctrl.flush_d = 1'b1;
      run_ctrl.flush_e = 1'b1;
    end else if (run_lw) begin
      run_ctrl.stall_f = 1'b1;
      run_ctrl.stall_d = 1'b1;
      run_ctrl.flush_e = 1'b1;
    end
  end

  always_comb begin
    ctrl      = run_ctrl;
    state_d   = state_q;
    timeout_d = timeout_q;
    tmr_clr   = 1'b0;
    tmr_load  = 1'b0;
    tmr_inc   = 1'b0;
    unique case (state_q)
      HzRun: begin
        if (mem_hold) begin
          state_d  = HzMemWait;
          tmr_load = 1'b1;
        end
      end
      HzMemWait: begin
        // Release is combinational: RUN rules already apply in the ready cycle.
        if (!mem_hold) begin
          state_d = HzRun;
          tmr_clr = 1'b1;
        end else if (tmr_hit) begin
          state_d   = HzTimeout;
          timeout_d = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      HzTimeout: begin
        ctrl = HzCtrlMemStall;
      end
      default: begin
        state_d = HzRun;
        tmr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HzRun;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  hz_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tmr_clr),
    .load (tmr_load),
    .inc  (tmr_inc),
    .hit  (tmr_hit)
  );

  assign StallF      = ctrl.stall_f;
  assign StallD      = ctrl.stall_d;
  assign StallE      = ctrl.stall_e;
  assign StallM      = ctrl.stall_m;
  assign FlushD      = ctrl.flush_d;
  assign FlushE      = ctrl.flush_e;
  assign FlushW      = ctrl.flush_w;
  assign mem_timeout = timeout_q;
  assign state_o     = state_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_lw_q, perf_mem_q, perf_fl_q;
  logic        not_timeout;

  assign not_timeout = (state_q != HzTimeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lw_q  <= '0;
      perf_mem_q <= '0;
      perf_fl_q  <= '0;
    end else begin
      if (not_timeout && run_lw) perf_lw_q <= perf_lw_q + 32'd1;
      if (ctrl.stall_m)          perf_mem_q <= perf_mem_q + 32'd1;
      if (not_timeout && run_br) perf_fl_q <= perf_fl_q + 32'd1;
    end
  end

  assign perf_lw_stalls  = perf_lw_q;
  assign perf_mem_stalls = perf_mem_q;
  assign perf_flushes    = perf_fl_q;
`endif

endmodule
